// File: rtl/img_pkg.sv
// Shared geometry for the four-bank image RAM and the blocks that fill or read it.
package img_pkg;

  localparam int unsigned IMG_ADDR_W = 13;
  localparam int unsigned IMG_DATA_W = 8;
  localparam int unsigned BANK_NUM   = 4;
  localparam int unsigned BANK_CAP   = 8192;
  localparam int unsigned BANK_SEL_W = $clog2(BANK_NUM);
  localparam int unsigned CAP_W      = $clog2(BANK_CAP) + 1;
  localparam int unsigned AREA_W     = 2 * CAP_W;

  typedef enum logic {StIdle, StRun} wr_state_e;

  // ceil(v/2) kept 33 bits wide so v = 2^32-1 cannot wrap.
  function automatic logic [32:0] half_up(input logic [31:0] v);
    return ({1'b0, v} + 33'd1) >> 1;
  endfunction

endpackage

// File: rtl/img_wr_addr_gen.sv
// Raster row/column walker producing the 2x2-interleaved bank select and bank address.
module img_wr_addr_gen
  import img_pkg::*;
#(
  parameter int unsigned ADDR_W = IMG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_step,
  input  logic [31:0]           i_img_x,
  input  logic [ADDR_W-1:0]     i_hx,
  output logic [31:0]           o_row,
  output logic [BANK_SEL_W-1:0] o_bank,
  output logic [ADDR_W-1:0]     o_addr,
  output logic                  o_col_last
);

  logic [31:0]       r_row;
  logic [31:0]       r_col;
  logic [ADDR_W-1:0] r_row_base;

  assign o_row      = r_row;
  assign o_col_last = (r_col == i_img_x - 32'd1);
  assign o_bank     = {r_row[0], r_col[0]};
  assign o_addr     = r_row_base + r_col[ADDR_W:1];

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_row      <= '0;
      r_col      <= '0;
      r_row_base <= '0;
    end else if (i_step) begin
      if (o_col_last) begin
        r_col <= '0;
        r_row <= r_row + 32'd1;
        // Odd rows close a bank row pair, so the base moves one half-width on.
        if (r_row[0]) begin
          r_row_base <= r_row_base + i_hx;
        end
      end else begin
        r_col <= r_col + 32'd1;
      end
    end
  end

endmodule

// File: rtl/img_ram_writer.sv
// Raster pixel writer into four 2x2-interleaved RAM banks; frame size is checked at start
// and one pixel per cycle is sustained.
module img_ram_writer
  import img_pkg::*;
#(
  parameter int unsigned ADDR_W = IMG_ADDR_W,
  parameter int unsigned DATA_W = IMG_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       img0x,
  input  logic [31:0]       img0y,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              ena1,
  output logic              ena2,
  output logic              ena3,
  output logic              ena4,
  output logic              wea1,
  output logic              wea2,
  output logic              wea3,
  output logic              wea4,
  output logic [ADDR_W-1:0] AA1,
  output logic [ADDR_W-1:0] AA2,
  output logic [ADDR_W-1:0] AA3,
  output logic [ADDR_W-1:0] AA4,
  output logic [DATA_W-1:0] DA1,
  output logic [DATA_W-1:0] DA2,
  output logic [DATA_W-1:0] DA3,
  output logic [DATA_W-1:0] DA4,
  output logic [31:0]       row_signal,
  output logic              busy,
  output logic              done,
  output logic              size_err
);

  wr_state_e             r_state, w_state_next;
  logic [31:0]           r_img_x, r_img_y;
  logic [ADDR_W-1:0]     r_hx;
  logic [32:0]           w_hx_req, w_hy_req;
  logic [AREA_W-1:0]     w_area;
  logic                  w_start_idle, w_size_zero, w_size_big, w_start_ok;
  logic                  w_accept, w_last, w_col_last;
  logic [31:0]           w_row;
  logic [BANK_SEL_W-1:0] w_bank;
  logic [ADDR_W-1:0]     w_addr;
  logic [BANK_NUM-1:0]   r_en;
  logic [ADDR_W-1:0]     r_aa [BANK_NUM];
  logic [DATA_W-1:0]     r_da;
  logic [31:0]           r_row_sig;
  logic                  r_busy, r_done, r_size_err;

  assign w_hx_req     = half_up(img0x);
  assign w_hy_req     = half_up(img0y);
  assign w_area       = AREA_W'(w_hx_req[CAP_W-1:0]) * AREA_W'(w_hy_req[CAP_W-1:0]);
  assign w_start_idle = (r_state == StIdle) && start;
  assign w_size_zero  = (img0x == 32'd0) || (img0y == 32'd0);
  // The wide halves are tested first, so the narrow product only matters when it cannot wrap.
  assign w_size_big   = (w_hx_req > 33'(BANK_CAP)) || (w_hy_req > 33'(BANK_CAP)) ||
                        (w_area > AREA_W'(BANK_CAP));

  assign s_ready  = (r_state == StRun) && !rst;
  assign w_accept = s_valid && s_ready;
  assign w_last   = w_accept && w_col_last && (w_row == r_img_y - 32'd1);

  always_comb begin
    w_state_next = r_state;
    w_start_ok   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start_idle && !w_size_zero && !w_size_big) begin
          w_state_next = StRun;
          w_start_ok   = 1'b1;
        end
      end
      StRun: begin
        if (w_last) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  img_wr_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_start_ok),
    .i_step    (w_accept),
    .i_img_x   (r_img_x),
    .i_hx      (r_hx),
    .o_row     (w_row),
    .o_bank    (w_bank),
    .o_addr    (w_addr),
    .o_col_last(w_col_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_img_x    <= '0;
      r_img_y    <= '0;
      r_hx       <= '0;
      r_en       <= '0;
      r_da       <= '0;
      r_row_sig  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_size_err <= 1'b0;
      for (int i = 0; i < BANK_NUM; i++) r_aa[i] <= '0;
    end else begin
      r_state    <= w_state_next;
      r_done     <= (w_start_idle && w_size_zero) || w_last;
      r_size_err <= w_start_idle && !w_size_zero && w_size_big;
      // Held through the done cycle of the frame.
      r_busy     <= (w_state_next == StRun) || w_last;
      if (w_start_ok) begin
        r_img_x <= img0x;
        r_img_y <= img0y;
        r_hx    <= w_hx_req[ADDR_W-1:0];
      end
      if ((w_start_idle && w_size_zero) || w_start_ok) begin
        r_row_sig <= '0;
      end else if (w_accept && w_col_last) begin
        r_row_sig <= r_row_sig + 32'd1;
      end
      r_en <= '0;
      if (w_accept) begin
        r_en[w_bank] <= 1'b1;
        r_aa[w_bank] <= w_addr;
        r_da         <= s_data;
      end
    end
  end

  assign ena1       = r_en[0];
  assign ena2       = r_en[1];
  assign ena3       = r_en[2];
  assign ena4       = r_en[3];
  assign wea1       = r_en[0];
  assign wea2       = r_en[1];
  assign wea3       = r_en[2];
  assign wea4       = r_en[3];
  assign AA1        = r_aa[0];
  assign AA2        = r_aa[1];
  assign AA3        = r_aa[2];
  assign AA4        = r_aa[3];
  assign DA1        = r_da;
  assign DA2        = r_da;
  assign DA3        = r_da;
  assign DA4        = r_da;
  assign row_signal = r_row_sig;
  assign busy       = r_busy;
  assign done       = r_done;
  assign size_err   = r_size_err;

endmodule

// File: tb/tb_img_ram_writer.sv
// Bench for img_ram_writer: frames are driven with fixed and random pixels and gaps, and the
// recorded bank writes are compared with a raster-order model of the 2x2 bank interleave.
module tb_img_ram_writer;
  import img_pkg::*;

  localparam int unsigned AW = IMG_ADDR_W;
  localparam int unsigned DW = IMG_DATA_W;

  logic          clk = 1'b0;
  logic          rst, start, s_valid;
  logic [31:0]   img0x, img0y;
  logic [DW-1:0] s_data;
  logic          s_ready, busy, done, size_err;
  logic          ena1, ena2, ena3, ena4, wea1, wea2, wea3, wea4;
  logic [AW-1:0] AA1, AA2, AA3, AA4;
  logic [DW-1:0] DA1, DA2, DA3, DA4;
  logic [31:0]   row_signal;

  img_ram_writer dut (
    .clk(clk), .rst(rst), .start(start), .img0x(img0x), .img0y(img0y),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .ena1(ena1), .ena2(ena2), .ena3(ena3), .ena4(ena4),
    .wea1(wea1), .wea2(wea2), .wea3(wea3), .wea4(wea4),
    .AA1(AA1), .AA2(AA2), .AA3(AA3), .AA4(AA4),
    .DA1(DA1), .DA2(DA2), .DA3(DA3), .DA4(DA4),
    .row_signal(row_signal), .busy(busy), .done(done), .size_err(size_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int bank;
    int addr;
    int data;
    int rowsig;
    bit dn;
    bit ok;
    bit by;
    int cyc;
  } wr_t;

  wr_t            obs_q[$];
  wr_t            exp_q[$];
  logic [DW-1:0]  pix_q[$];
  int             done_cnt, serr_cnt, rdy_cnt, cyc_cnt;
  wire [3:0]      ena_v = {ena4, ena3, ena2, ena1};
  wire [3:0]      wea_v = {wea4, wea3, wea2, wea1};

  always @(posedge clk) cyc_cnt++;

  // Records every bank write and counts pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (size_err === 1'b1) serr_cnt++;
    if (s_ready === 1'b1) rdy_cnt++;
    if ((ena_v | wea_v) != 4'b0) begin
      wr_t w;
      w.bank = 0;
      for (int i = 0; i < 4; i++) if (ena_v[i]) w.bank = i + 1;
      case (w.bank)
        1: w.addr = int'(AA1);
        2: w.addr = int'(AA2);
        3: w.addr = int'(AA3);
        default: w.addr = int'(AA4);
      endcase
      w.data   = int'(DA1);
      w.rowsig = int'(row_signal);
      w.dn     = done;
      w.by     = busy;
      w.ok     = $onehot(ena_v) && (ena_v == wea_v) && (DA1 == DA2) && (DA1 == DA3) &&
                 (DA1 == DA4);
      w.cyc    = cyc_cnt;
      obs_q.push_back(w);
    end
  end

  function automatic string fmt(wr_t w);
    return $sformatf("bank%0d addr%0d data%0d rowsig%0d done%0b onehot%0b busy%0b",
                     w.bank, w.addr, w.data, w.rowsig, w.dn, w.ok, w.by);
  endfunction

  // Reference: pixel k of a raster frame lands in bank by (row,col) parity at half-res address.
  task automatic model_frame(input int x, input int y);
    int hx;
    wr_t w;
    hx = (x + 1) / 2;
    for (int r = 0; r < y; r++) begin
      for (int c = 0; c < x; c++) begin
        w.bank   = 1 + 2 * (r % 2) + (c % 2);
        w.addr   = (r / 2) * hx + c / 2;
        w.data   = int'(pix_q[r * x + c]);
        w.rowsig = (c == x - 1) ? r + 1 : r;
        w.dn     = (r == y - 1) && (c == x - 1);
        w.ok     = 1'b1;
        w.by     = 1'b1;
        w.cyc    = 0;
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic clear_obs();
    obs_q.delete();
    exp_q.delete();
    done_cnt = 0;
    serr_cnt = 0;
    rdy_cnt  = 0;
  endtask

  task automatic fill_pix(input int n, input bit rnd);
    pix_q.delete();
    for (int k = 0; k < n; k++) pix_q.push_back(rnd ? DW'($urandom) : DW'(k + 1));
  endtask

  // gap: 0 continuous, 1 alternate cycles, 2 random; mid_start pulses start at that cycle.
  task automatic drive_frame(input int x, input int y, input int gap, input int mid_start,
                             output bit timeout);
    int idx = 0;
    int cyc = 0;
    int n   = x * y;
    bit acc;
    start = 1'b1;
    img0x = x;
    img0y = y;
    @(posedge clk); #1;
    start = 1'b0;
    while (idx < n && cyc < 4 * n + 20) begin
      case (gap)
        0:       s_valid = 1'b1;
        1:       s_valid = (cyc % 2 == 0);
        default: s_valid = ($urandom_range(0, 2) != 0);
      endcase
      s_data = pix_q[idx];
      start  = (cyc == mid_start);
      if (start) begin
        img0x = 0;
        img0y = 0;
      end
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    start   = 1'b0;
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    timeout = (idx != n);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; s_valid = 1'b1; img0x = 4; img0y = 2; s_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_ready, busy, done, size_err} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {s_ready, busy, done, size_err});
    end
    checks++;
    if ((ena_v | wea_v) !== 4'b0) begin
      errors++; $display("FAIL reset_enables got %b want 0", ena_v | wea_v);
    end
    checks++;
    if ({AA1, AA2, AA3, AA4, DA1} !== '0 || row_signal !== 32'd0) begin
      errors++; $display("FAIL reset_data AA1 %0d DA1 %0d row %0d want 0", AA1, DA1, row_signal);
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; s_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_start_blocked got ready %b busy %b want 0 0", s_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_frame_4x2();
    int eb[8] = '{1, 2, 1, 2, 3, 4, 3, 4};
    int ea[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    bit to;
    clear_obs(); fill_pix(8, 1'b0); model_frame(4, 2);
    drive_frame(4, 2, 0, -1, to);
    checks++;
    if (to) begin errors++; $display("FAIL f4x2_timeout got stalled want 8 accepts"); end
    checks++;
    if (obs_q.size() != 8) begin
      errors++; $display("FAIL f4x2_count got %0d want 8", obs_q.size());
    end
    for (int k = 0; k < 8 && k < obs_q.size(); k++) begin
      checks++;
      if (fmt(obs_q[k]) != fmt(exp_q[k]) || obs_q[k].bank != eb[k] || obs_q[k].addr != ea[k]
          || obs_q[k].data != k + 1) begin
        errors++;
        $display("FAIL f4x2_write%0d got %s want %s", k, fmt(obs_q[k]), fmt(exp_q[k]));
      end
    end
    @(negedge clk);
    checks++;
    if (done_cnt != 1 || row_signal !== 32'd2 || busy !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL f4x2_end got done%0d row%0d busy%b ready%b want 1 2 0 0",
               done_cnt, row_signal, busy, s_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_frame_3x3();
    bit to;
    clear_obs(); fill_pix(9, 1'b1); model_frame(3, 3);
    drive_frame(3, 3, 0, -1, to);
    checks++;
    if (to || obs_q.size() != 9) begin
      errors++; $display("FAIL f3x3_count got %0d timeout %b want 9 0", obs_q.size(), to);
    end
    for (int k = 0; k < 9 && k < obs_q.size(); k++) begin
      checks++;
      if (fmt(obs_q[k]) != fmt(exp_q[k])) begin
        errors++;
        $display("FAIL f3x3_write%0d got %s want %s", k, fmt(obs_q[k]), fmt(exp_q[k]));
      end
    end
    checks++;
    if (obs_q.size() == 9 && (obs_q[5].bank != 3 || obs_q[5].addr != 1 || obs_q[7].bank != 2 ||
        obs_q[7].addr != 2 || obs_q[8].rowsig != 3 || !obs_q[8].dn)) begin
      errors++;
      $display("FAIL f3x3_spot got p5 %s p7 %s want bank3 addr1, bank2 addr2",
               fmt(obs_q[5]), fmt(obs_q[7]));
    end
  endtask

  task automatic test_back_to_back_gaps();
    bit to;
    clear_obs(); fill_pix(8, 1'b0); model_frame(4, 2);
    drive_frame(4, 2, 1, -1, to);
    checks++;
    if (to || obs_q.size() != 8) begin
      errors++; $display("FAIL gaps_count got %0d timeout %b want 8 0", obs_q.size(), to);
    end
    for (int k = 0; k < 8 && k < obs_q.size(); k++) begin
      checks++;
      if (fmt(obs_q[k]) != fmt(exp_q[k]) || (k > 0 && obs_q[k].cyc - obs_q[k-1].cyc != 2)) begin
        errors++;
        $display("FAIL gaps_write%0d got %s want %s spaced 2", k, fmt(obs_q[k]), fmt(exp_q[k]));
      end
    end
  endtask

  task automatic test_size_err();
    logic [31:0] tx[6] = '{257, 256, 1, 1, 32'hFFFF_FFFF, 181};
    logic [31:0] ty[6] = '{128, 128, 16385, 16384, 1, 181};
    bit          te[6] = '{1, 0, 1, 0, 1, 1};
    clear_obs();
    start = 1'b1; img0x = 200; img0y = 200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (serr_cnt != 1 || obs_q.size() != 0 || rdy_cnt != 0 || row_signal !== 32'd2) begin
      errors++;
      $display("FAIL size_err_200 got err%0d writes%0d ready%0d row%0d want 1 0 0 2",
               serr_cnt, obs_q.size(), rdy_cnt, row_signal);
    end
    @(posedge clk); #1;
    clear_obs();
    start = 1'b1; img0x = 0; img0y = 5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (done_cnt != 1 || serr_cnt != 0 || row_signal !== 32'd0 || rdy_cnt != 0) begin
      errors++;
      $display("FAIL zero_size got done%0d err%0d row%0d ready%0d want 1 0 0 0",
               done_cnt, serr_cnt, row_signal, rdy_cnt);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      start = 1'b1; img0x = tx[i]; img0y = ty[i];
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (size_err !== te[i] || busy !== !te[i] || s_ready !== !te[i]) begin
        errors++;
        $display("FAIL size_bound%0d %0dx%0d got err%b busy%b ready%b want err%b",
                 i, tx[i], ty[i], size_err, busy, s_ready, te[i]);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
  endtask

  task automatic test_rst_mid();
    int abort_at[2] = '{3, 5};
    bit to;
    for (int a = 0; a < 2; a++) begin
      clear_obs(); fill_pix(8, 1'b1); model_frame(4, 2);
      start = 1'b1; img0x = 4; img0y = 2;
      @(posedge clk); #1;
      start = 1'b0; s_valid = 1'b1;
      for (int i = 0; i < abort_at[a]; i++) begin
        s_data = pix_q[i];
        @(posedge clk); #1;
      end
      rst = 1'b1; start = 1'b1; s_data = pix_q[abort_at[a]];
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0; s_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ((ena_v | wea_v) !== 4'b0 || row_signal !== 32'd0 || busy !== 1'b0 || s_ready !== 1'b0)
      begin
        errors++;
        $display("FAIL rst_mid%0d got en%b row%0d busy%b ready%b want 0 0 0 0",
                 abort_at[a], ena_v, row_signal, busy, s_ready);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs_q.size() != abort_at[a]) begin
        errors++;
        $display("FAIL rst_mid_count got %0d want %0d", obs_q.size(), abort_at[a]);
      end
      for (int k = 0; k < abort_at[a] && k < obs_q.size(); k++) begin
        checks++;
        if (fmt(obs_q[k]) != fmt(exp_q[k])) begin
          errors++;
          $display("FAIL rst_mid_write%0d got %s want %s", k, fmt(obs_q[k]), fmt(exp_q[k]));
        end
      end
    end
    clear_obs(); fill_pix(8, 1'b0); model_frame(4, 2);
    drive_frame(4, 2, 0, -1, to);
    checks++;
    if (to || obs_q.size() != 8) begin
      errors++; $display("FAIL rst_redo_count got %0d timeout %b want 8 0", obs_q.size(), to);
    end
    for (int k = 0; k < 8 && k < obs_q.size(); k++) begin
      checks++;
      if (fmt(obs_q[k]) != fmt(exp_q[k])) begin
        errors++;
        $display("FAIL rst_redo_write%0d got %s want %s", k, fmt(obs_q[k]), fmt(exp_q[k]));
      end
    end
  endtask

  task automatic test_start_in_run();
    bit to;
    clear_obs(); fill_pix(8, 1'b1); model_frame(4, 2);
    drive_frame(4, 2, 0, 3, to);
    checks++;
    if (to || obs_q.size() != 8 || done_cnt != 1 || serr_cnt != 0) begin
      errors++;
      $display("FAIL start_in_run got writes%0d done%0d err%0d timeout%b want 8 1 0 0",
               obs_q.size(), done_cnt, serr_cnt, to);
    end
    for (int k = 0; k < 8 && k < obs_q.size(); k++) begin
      checks++;
      if (fmt(obs_q[k]) != fmt(exp_q[k])) begin
        errors++;
        $display("FAIL start_in_run_write%0d got %s want %s", k, fmt(obs_q[k]), fmt(exp_q[k]));
      end
    end
  endtask

  task automatic test_random();
    int x, y;
    bit to;
    for (int f = 0; f < 8; f++) begin
      x = $urandom_range(1, 9);
      y = $urandom_range(1, 6);
      clear_obs(); fill_pix(x * y, 1'b1); model_frame(x, y);
      drive_frame(x, y, $urandom_range(0, 2), -1, to);
      checks++;
      if (to || obs_q.size() != x * y || done_cnt != 1) begin
        errors++;
        $display("FAIL rand%0d %0dx%0d got writes%0d done%0d timeout%b want %0d 1 0",
                 f, x, y, obs_q.size(), done_cnt, to, x * y);
      end
      for (int k = 0; k < x * y && k < obs_q.size(); k++) begin
        checks++;
        if (fmt(obs_q[k]) != fmt(exp_q[k])) begin
          errors++;
          $display("FAIL rand%0d_write%0d got %s want %s", f, k, fmt(obs_q[k]), fmt(exp_q[k]));
        end
      end
      @(negedge clk);
      checks++;
      if (row_signal !== 32'(y) || busy !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_end got row%0d busy%b want %0d 0", f, row_signal, busy, y);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    cyc_cnt = 0;
    test_reset();
    test_frame_4x2();
    test_size_err();
    test_frame_3x3();
    test_back_to_back_gaps();
    test_rst_mid();
    test_start_in_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
